// File: rtl/mcycle_cpu.sv
// Multi-cycle CPU core: IDLE/FETCHA/FETCHB/EXECA/EXECB sequencer, PC, register file, ALU with C/Z flags.
// Optional performance counters are compiled in when CPU_PERF_EN is defined.
module mcycle_cpu #(
    parameter int DW   = 8,
    parameter int AW   = 8,
    parameter int NREG = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          halt,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic [2:0]    state,
    output logic [AW-1:0] pc_out,
    output logic          cflag,
    output logic          zflag,
    input  logic [2:0]    dbg_sel,
    output logic [DW-1:0] dbg_data
`ifdef CPU_PERF_EN
    ,
    output logic [31:0]   perf_retired,
    output logic [31:0]   perf_wait
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCHA = 3'd1;
    localparam logic [2:0] S_FETCHB = 3'd2;
    localparam logic [2:0] S_EXECA  = 3'd3;
    localparam logic [2:0] S_EXECB  = 3'd4;

    localparam logic [4:0] OP_NOP = 5'b00000;
    localparam logic [4:0] OP_MOV = 5'b00001;
    localparam logic [4:0] OP_ADD = 5'b00100;
    localparam logic [4:0] OP_SUB = 5'b00101;
    localparam logic [4:0] OP_AND = 5'b00110;
    localparam logic [4:0] OP_OR  = 5'b00111;
    localparam logic [4:0] OP_LD  = 5'b01000;
    localparam logic [4:0] OP_LDI = 5'b01010;
    localparam logic [4:0] OP_ST  = 5'b01100;
    localparam logic [4:0] OP_STS = 5'b01101;
    localparam logic [4:0] OP_JMP = 5'b10000;
    localparam logic [4:0] OP_JZ  = 5'b10001;
    localparam logic [4:0] OP_JC  = 5'b10010;
    localparam logic [4:0] OP_HLT = 5'b11111;

    logic [2:0]    state_q;
    logic [AW-1:0] pc_q;
    logic [DW-1:0] opcode_q, operand_q, res_q;
    logic          c_q, z_q, c_new_q, z_new_q, halt_req_q;
    logic [DW-1:0] rf [NREG];

    logic [4:0]    op;
    logic [2:0]    rc, ra, rb;
    logic [DW-1:0] ra_val, rb_val, rc_val;
    logic [DW:0]   alu_out;
    logic          is_mem, writes_reg, sets_flags;

    // Returns {carry/borrow, result}; result is truncated to DW.
    function automatic logic [DW:0] alu_fn(input logic [4:0] f, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b, input logic [DW-1:0] imm);
        case (f)
            OP_ADD:  return {1'b0, a} + {1'b0, b};
            OP_SUB:  return {1'b0, a} - {1'b0, b};
            OP_AND:  return {1'b0, a & b};
            OP_OR:   return {1'b0, a | b};
            OP_MOV:  return {1'b0, a};
            OP_LDI:  return {1'b0, imm};
            default: return '0;
        endcase
    endfunction

    function automatic logic [AW-1:0] to_addr(input logic [DW-1:0] d);
        return AW'(d);
    endfunction

    assign op = opcode_q[DW-1:DW-5];
    assign rc = opcode_q[2:0];
    assign ra = operand_q[DW-1:DW-3];
    assign rb = operand_q[DW-4:DW-6];

    assign ra_val   = (int'(ra) < NREG) ? rf[ra] : '0;
    assign rb_val   = (int'(rb) < NREG) ? rf[rb] : '0;
    assign rc_val   = (int'(rc) < NREG) ? rf[rc] : '0;
    assign dbg_data = (int'(dbg_sel) < NREG) ? rf[dbg_sel] : '0;

    assign alu_out    = alu_fn(op, ra_val, rb_val, operand_q);
    assign is_mem     = (op == OP_LD) || (op == OP_ST) || (op == OP_STS);
    assign sets_flags = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    assign writes_reg = sets_flags || (op == OP_MOV) || (op == OP_LDI) || (op == OP_LD);

    assign state  = state_q;
    assign pc_out = pc_q;
    assign cflag  = c_q;
    assign zflag  = z_q;

    // Strobes decode straight from state so reset drops them in the same cycle.
    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = pc_q;
        mem_wdata = rc_val;
        case (state_q)
            S_FETCHA, S_FETCHB: mem_rd = 1'b1;
            S_EXECA: begin
                if (op == OP_LD) begin
                    mem_rd   = 1'b1;
                    mem_addr = to_addr(ra_val);
                end else if (op == OP_ST) begin
                    mem_wr   = 1'b1;
                    mem_addr = to_addr(ra_val);
                end else if (op == OP_STS) begin
                    mem_wr   = 1'b1;
                    mem_addr = to_addr(operand_q);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            opcode_q   <= '0;
            operand_q  <= '0;
            res_q      <= '0;
            c_q        <= 1'b0;
            z_q        <= 1'b0;
            c_new_q    <= 1'b0;
            z_new_q    <= 1'b0;
            halt_req_q <= 1'b0;
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            if (state_q != S_IDLE) halt_req_q <= halt_req_q | halt;
            case (state_q)
                S_IDLE: if (run && !halt) state_q <= S_FETCHA;
                S_FETCHA: if (mem_ready) begin
                    opcode_q <= mem_rdata;
                    pc_q     <= pc_q + AW'(1);
                    state_q  <= S_FETCHB;
                end
                S_FETCHB: if (mem_ready) begin
                    operand_q <= mem_rdata;
                    pc_q      <= pc_q + AW'(1);
                    state_q   <= S_EXECA;
                end
                S_EXECA: if (!is_mem || mem_ready) begin
                    res_q   <= (op == OP_LD) ? mem_rdata : alu_out[DW-1:0];
                    c_new_q <= alu_out[DW];
                    z_new_q <= (alu_out[DW-1:0] == '0);
                    state_q <= S_EXECB;
                end
                S_EXECB: begin
                    if (writes_reg && int'(rc) < NREG) rf[rc] <= res_q;
                    if (sets_flags) begin
                        c_q <= c_new_q;
                        z_q <= z_new_q;
                    end
                    if ((op == OP_JMP) || (op == OP_JZ && z_q) || (op == OP_JC && c_q))
                        pc_q <= to_addr(operand_q);
                    if (halt_req_q || halt || op == OP_HLT) begin
                        state_q    <= S_IDLE;
                        halt_req_q <= 1'b0;
                    end else begin
                        state_q <= S_FETCHA;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef CPU_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_retired <= '0;
            perf_wait    <= '0;
        end else begin
            if (state_q == S_EXECB) perf_retired <= perf_retired + 32'd1;
            if ((mem_rd || mem_wr) && !mem_ready) perf_wait <= perf_wait + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mcycle_cpu.sv
// Directed bench for mcycle_cpu (DW=AW=8): program image plus write-capturing data memory.
module tb_mcycle_cpu;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       halt = 1'b0;
    logic [7:0] mem_addr, mem_wdata, mem_rdata, pc_out, dbg_data;
    logic       mem_rd, mem_wr, cflag, zflag;
    logic       mem_ready = 1'b1;
    logic [2:0] state, dbg_sel = 3'd0;

    logic [7:0] prog [256];
    logic [7:0] dmem [256];
    logic       written [256];
    int         wr_cnt;
    logic       clr = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    mcycle_cpu #(.DW(8), .AW(8), .NREG(8)) dut (
        .clk(clk), .rst(rst), .run(run), .halt(halt),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .state(state), .pc_out(pc_out),
        .cflag(cflag), .zflag(zflag), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    assign mem_rdata = written[mem_addr] ? dmem[mem_addr] : prog[mem_addr];

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) written[i] <= 1'b0;
            wr_cnt <= 0;
        end else if (mem_wr && mem_ready) begin
            dmem[mem_addr]    <= mem_wdata;
            written[mem_addr] <= 1'b1;
            wr_cnt            <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; clr = 1'b1; run = 1'b0; halt = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0; clr = 1'b0;
    endtask

    task automatic load(input logic [7:0] img [], input int base);
        for (int i = 0; i < 256; i++) prog[i] = 8'h00;
        for (int i = 0; i < img.size(); i++) prog[base + i] = img[i];
    endtask

    task automatic start();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic run_until_idle(output int cycles);
        cycles = 0;
        while (state != 3'd0 && cycles < 300) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic wait_state_pc(input logic [2:0] s, input logic [7:0] p, input string tag);
        int n = 0;
        while (!(state == s && pc_out == p) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < 100), 32'd1);
    endtask

    task automatic get_reg(input logic [2:0] s, output logic [7:0] v);
        dbg_sel = s;
        #1;
        v = dbg_data;
    endtask

    initial begin
        int cyc, cyc2;
        logic [7:0] v;
        logic [7:0] img [];

        for (int i = 0; i < 256; i++) begin
            prog[i] = 8'h00;
            dmem[i] = 8'h00;
        end
        do_reset();

        check("reset state", state, 0);
        check("reset pc", pc_out, 0);
        check("reset mem_rd", mem_rd, 0);
        check("reset mem_wr", mem_wr, 0);
        check("reset flags", {cflag, zflag}, 0);
        get_reg(3'd3, v);
        check("reset r3", v, 0);

        // run with halt held: halt wins, core stays idle
        run = 1'b1; halt = 1'b1;
        @(negedge clk);
        run = 1'b0; halt = 1'b0;
        check("idle halt wins", state, 0);

        // 1: LDI r1,5; LDI r2,3; ADD r3,r1,r2; HLT
        img = '{8'h51, 8'h05, 8'h52, 8'h03, 8'h23, 8'h28, 8'hF8, 8'h00};
        load(img, 0);
        start();
        run_until_idle(cyc);
        check("t1 state", state, 0);
        check("t1 pc", pc_out, 8);
        check("t1 cycles", cyc, 16);
        get_reg(3'd3, v);
        check("t1 r3", v, 8'h08);
        check("t1 C", cflag, 0);
        check("t1 Z", zflag, 0);

        // 2: FF+01 sets C and Z, then JZ 0x20 where HLT sits
        do_reset();
        img = '{8'h51, 8'hFF, 8'h52, 8'h01, 8'h23, 8'h28, 8'h88, 8'h20};
        load(img, 0);
        prog[8'h20] = 8'hF8;
        start();
        wait_state_pc(3'd1, 8'h20, "t2 reach 0x20");
        check("t2 fetch addr", mem_addr, 8'h20);
        check("t2 fetch rd", mem_rd, 1);
        run_until_idle(cyc);
        check("t2 pc", pc_out, 8'h22);
        get_reg(3'd3, v);
        check("t2 r3", v, 8'h00);
        check("t2 C", cflag, 1);
        check("t2 Z", zflag, 1);

        // 3: three wait states on the first opcode fetch
        do_reset();
        img = '{8'h55, 8'h77, 8'hF8, 8'h00};
        load(img, 0);
        mem_ready = 1'b0;
        start();
        for (int i = 0; i < 4; i++) begin
            check("t3 hold state", state, 1);
            check("t3 hold pc", pc_out, 0);
            check("t3 hold addr", mem_addr, 0);
            if (i == 3) mem_ready = 1'b1;
            @(negedge clk);
        end
        run_until_idle(cyc);
        check("t3 cycles", cyc + 4, 11);
        get_reg(3'd5, v);
        check("t3 r5", v, 8'h77);

        // 4: ST r1,[r2]; LD r4,[r2]; STS r4,[0x50]
        do_reset();
        img = '{8'h51, 8'hA5, 8'h52, 8'h40, 8'h61, 8'h40, 8'h44, 8'h40,
                8'h6C, 8'h50, 8'hF8, 8'h00};
        load(img, 0);
        start();
        run_until_idle(cyc);
        check("t4 mem40", dmem[8'h40], 8'hA5);
        check("t4 mem50", dmem[8'h50], 8'hA5);
        check("t4 writes", wr_cnt, 2);
        get_reg(3'd4, v);
        check("t4 r4", v, 8'hA5);
        check("t4 pc", pc_out, 12);

        // 5: halt pulse during ADD's EXECA, then resume
        do_reset();
        img = '{8'h51, 8'h05, 8'h52, 8'h03, 8'h23, 8'h28, 8'h56, 8'h09, 8'hF8, 8'h00};
        load(img, 0);
        start();
        wait_state_pc(3'd3, 8'h06, "t5 reach ADD");
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        run_until_idle(cyc);
        check("t5 halt cycles", cyc, 1);
        check("t5 pc", pc_out, 6);
        get_reg(3'd3, v);
        check("t5 r3", v, 8'h08);
        get_reg(3'd6, v);
        check("t5 r6 before", v, 8'h00);
        start();
        run_until_idle(cyc);
        get_reg(3'd6, v);
        check("t5 r6 after", v, 8'h09);
        check("t5 pc after", pc_out, 10);

        // 6: reset while ST is stalled in EXECA
        do_reset();
        img = '{8'h51, 8'hA5, 8'h52, 8'h40, 8'h61, 8'h40, 8'hF8, 8'h00};
        load(img, 0);
        start();
        wait_state_pc(3'd3, 8'h06, "t6 reach ST");
        mem_ready = 1'b0;
        #1;
        check("t6 wr pending", mem_wr, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6 wr dropped", mem_wr, 0);
        check("t6 state", state, 0);
        check("t6 pc", pc_out, 0);
        get_reg(3'd1, v);
        check("t6 r1", v, 8'h00);
        check("t6 no write", wr_cnt, 0);
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        check("t6 stays idle", state, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
